// File: rtl/mem_store_if.sv
// mem_store_if: store request / BRAM write-port bundle for mem_store_unit.
//
// Signals
//   req_valid  pipeline -> unit   store request present
//   req_ready  unit -> pipeline   unit can accept a request this cycle
//   req_addr   pipeline -> unit   byte address
//   req_func3  pipeline -> unit   RV32 store func3 (000 SB, 001 SH, 010 SW)
//   req_data   pipeline -> unit   rs2 value (low 8/16/32 bits used)
//   mem_addr   unit -> memory     word address
//   mem_din    unit -> memory     lane-positioned write data
//   mem_we     unit -> memory     per-byte write enables
//   err        unit -> pipeline   one-cycle pulse on a rejected request
//   busy       unit -> pipeline   second half of a split store pending
//
// Modports: master = pipeline side, slave = store unit side.
interface mem_store_if #(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 14
);
    logic              req_valid;
    logic              req_ready;
    logic [WIDTH-1:0]  req_addr;
    logic [2:0]        req_func3;
    logic [WIDTH-1:0]  req_data;
    logic [AWIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_din;
    logic [3:0]        mem_we;
    logic              err;
    logic              busy;

    modport master (
        output req_valid, req_addr, req_func3, req_data,
        input  req_ready, mem_addr, mem_din, mem_we, err, busy
    );

    modport slave (
        input  req_valid, req_addr, req_func3, req_data,
        output req_ready, mem_addr, mem_din, mem_we, err, busy
    );
endinterface

// File: rtl/mem_store_unit.sv
// mem_store_unit: RV32 store path. Takes SB/SH/SW requests, positions the
// data in the 32-bit memory word, generates byte write enables and drives a
// synchronous-write BRAM port from registers. Stores that cross a word
// boundary are either split into two consecutive word writes
// (MISALIGN_SPLIT=1) or rejected with an err pulse (MISALIGN_SPLIT=0).
//
// Ports
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  mem_store_if.slave: request handshake in, BRAM write port out,
//        err / busy status out
module mem_store_unit #(
    parameter int WIDTH          = 32,
    parameter int AWIDTH         = 14,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    mem_store_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SECOND = 2'd1
    } state_t;

    state_t             state_q;
    logic [AWIDTH-1:0]  mem_addr_q;
    logic [WIDTH-1:0]   mem_din_q;
    logic [3:0]         mem_we_q;
    logic               err_q;
    logic               busy_q;

    // Second half of a split store, held until the following edge.
    logic [AWIDTH-1:0]  hi_addr_q;
    logic [WIDTH-1:0]   hi_din_q;
    logic [3:0]         hi_we_q;

    logic [1:0]         off;
    logic [AWIDTH-1:0]  wa;
    logic               legal;
    logic [7:0]         nmask;
    logic [WIDTH-1:0]   ndata;
    logic [7:0]         mask8;
    logic [63:0]        data64;
    logic               crosses;
    logic               accept;
    logic               reject;
    logic               unused_addr_bits;

    assign off = bus.req_addr[1:0];
    assign wa  = bus.req_addr[AWIDTH+1:2];
    assign unused_addr_bits = ^bus.req_addr[WIDTH-1:AWIDTH+2];

    // Size decode: byte mask and zero-extended data for the access width.
    always_comb begin
        legal = 1'b1;
        nmask = 8'h00;
        ndata = '0;
        case (bus.req_func3)
            3'b000: begin
                nmask = 8'h01;
                ndata = {24'h0, bus.req_data[7:0]};
            end
            3'b001: begin
                nmask = 8'h03;
                ndata = {16'h0, bus.req_data[15:0]};
            end
            3'b010: begin
                nmask = 8'h0F;
                ndata = bus.req_data;
            end
            default: legal = 1'b0;
        endcase
    end

    // Shift into an 8-lane (two-word) window; the upper four lanes are the
    // part that spills into the next word.
    assign mask8   = nmask << off;
    assign data64  = {32'h0, ndata} << {off, 3'b000};
    assign crosses = |mask8[7:4];

    assign bus.req_ready = (state_q == S_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign reject        = !legal || (crosses && !MISALIGN_SPLIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 4'b0000;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            hi_addr_q  <= '0;
            hi_din_q   <= '0;
            hi_we_q    <= 4'b0000;
        end else begin
            // Write enable and err are pulses; address/data hold otherwise.
            mem_we_q <= 4'b0000;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (reject) begin
                            err_q <= 1'b1;
                        end else begin
                            mem_addr_q <= wa;
                            mem_we_q   <= mask8[3:0];
                            mem_din_q  <= data64[31:0];
                            if (crosses) begin
                                // wa+1 wraps naturally at the top word.
                                hi_addr_q <= wa + AWIDTH'(1);
                                hi_we_q   <= mask8[7:4];
                                hi_din_q  <= data64[63:32];
                                busy_q    <= 1'b1;
                                state_q   <= S_SECOND;
                            end
                        end
                    end
                end
                S_SECOND: begin
                    mem_addr_q <= hi_addr_q;
                    mem_we_q   <= hi_we_q;
                    mem_din_q  <= hi_din_q;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// tb_mem_store_unit: directed bench for mem_store_unit. Instance A splits
// word-crossing stores, instance B rejects them.
module tb_mem_store_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_store_if #(.WIDTH(32), .AWIDTH(14)) bus_a ();
    mem_store_if #(.WIDTH(32), .AWIDTH(14)) bus_b ();

    mem_store_unit #(.WIDTH(32), .AWIDTH(14), .MISALIGN_SPLIT(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mem_store_unit #(.WIDTH(32), .AWIDTH(14), .MISALIGN_SPLIT(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req_a(input logic v, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
        bus_a.req_valid = v;
        bus_a.req_addr  = a;
        bus_a.req_func3 = f;
        bus_a.req_data  = d;
    endtask

    task automatic req_b(input logic v, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
        bus_b.req_valid = v;
        bus_b.req_addr  = a;
        bus_b.req_func3 = f;
        bus_b.req_data  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [13:0] addr, input logic [3:0] we,
                         input logic [31:0] din, input logic busy, input logic rdy, input logic err);
        chk({tag, ".addr"}, 32'(bus_a.mem_addr), 32'(addr));
        chk({tag, ".we"},   32'(bus_a.mem_we),   32'(we));
        chk({tag, ".din"},  bus_a.mem_din,       din);
        chk({tag, ".busy"}, 32'(bus_a.busy),     32'(busy));
        chk({tag, ".rdy"},  32'(bus_a.req_ready), 32'(rdy));
        chk({tag, ".err"},  32'(bus_a.err),      32'(err));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req_a(1'b0, 32'h0, 3'b000, 32'h0);
        req_b(1'b0, 32'h0, 3'b000, 32'h0);

        // Reset state (rst still high, so ready is low).
        tick();
        tick();
        chk_a("reset", 14'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reset.b_rdy", 32'(bus_b.req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset.rdy_after", 32'(bus_a.req_ready), 32'd1);

        // Aligned SW, then back-to-back SB and SH.
        req_a(1'b1, 32'h100, 3'b010, 32'hDEADBEEF);
        tick();
        chk_a("sw", 14'h40, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        req_a(1'b1, 32'h103, 3'b000, 32'h123456AB);
        tick();
        chk_a("sb", 14'h40, 4'b1000, 32'hAB000000, 1'b0, 1'b1, 1'b0);
        req_a(1'b1, 32'h102, 3'b001, 32'h0000CAFE);
        tick();
        chk_a("sh", 14'h40, 4'b1100, 32'hCAFE0000, 1'b0, 1'b1, 1'b0);
        req_a(1'b0, 32'h0, 3'b000, 32'h0);
        tick();
        chk_a("idle_hold", 14'h40, 4'b0000, 32'hCAFE0000, 1'b0, 1'b1, 1'b0);

        // Split SW; a held request during SECOND must wait.
        req_a(1'b1, 32'h102, 3'b010, 32'h11223344);
        tick();
        chk_a("split1", 14'h40, 4'b1100, 32'h33440000, 1'b1, 1'b0, 1'b0);
        req_a(1'b1, 32'h200, 3'b000, 32'h00000055);
        tick();
        chk_a("split2", 14'h41, 4'b0011, 32'h00001122, 1'b0, 1'b1, 1'b0);
        tick();
        chk_a("held_sb", 14'h80, 4'b0001, 32'h00000055, 1'b0, 1'b1, 1'b0);

        // Split at the top word wraps to word 0.
        req_a(1'b1, 32'h1FFFF, 3'b001, 32'h0000BEEF);
        tick();
        chk_a("wrap1", 14'h3FFF, 4'b1000, 32'hEF000000, 1'b1, 1'b0, 1'b0);
        req_a(1'b0, 32'h0, 3'b000, 32'h0);
        tick();
        chk_a("wrap2", 14'h0000, 4'b0001, 32'h000000BE, 1'b0, 1'b1, 1'b0);

        // Illegal func3 on the splitting instance.
        req_a(1'b1, 32'h10, 3'b011, 32'hFFFFFFFF);
        tick();
        chk_a("bad_f3", 14'h0000, 4'b0000, 32'h000000BE, 1'b0, 1'b1, 1'b1);
        req_a(1'b0, 32'h0, 3'b000, 32'h0);
        tick();
        chk_a("bad_f3_end", 14'h0000, 4'b0000, 32'h000000BE, 1'b0, 1'b1, 1'b0);

        // Reset during SECOND drops the pending write.
        req_a(1'b1, 32'h101, 3'b010, 32'hAABBCCDD);
        tick();
        chk_a("rst_split1", 14'h40, 4'b1110, 32'hBBCCDD00, 1'b1, 1'b0, 1'b0);
        req_a(1'b0, 32'h0, 3'b000, 32'h0);
        rst = 1'b1;
        tick();
        chk_a("rst_drop", 14'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_drop.rdy", 32'(bus_a.req_ready), 32'd1);
        tick();
        chk("rst_drop.we_after", 32'(bus_a.mem_we), 32'd0);

        // Non-splitting instance: legal non-crossing SH, then two rejects.
        req_b(1'b1, 32'h101, 3'b001, 32'h0000CAFE);
        tick();
        chk("b_sh.addr", 32'(bus_b.mem_addr), 32'h40);
        chk("b_sh.we",   32'(bus_b.mem_we),   32'b0110);
        chk("b_sh.din",  bus_b.mem_din,       32'h00CAFE00);
        chk("b_sh.err",  32'(bus_b.err),      32'd0);
        req_b(1'b1, 32'h104, 3'b011, 32'h12345678);
        tick();
        chk("b_f3.err", 32'(bus_b.err),    32'd1);
        chk("b_f3.we",  32'(bus_b.mem_we), 32'd0);
        req_b(1'b1, 32'h1, 3'b010, 32'h12345678);
        tick();
        chk("b_sw1.err",  32'(bus_b.err),      32'd1);
        chk("b_sw1.we",   32'(bus_b.mem_we),   32'd0);
        chk("b_sw1.busy", 32'(bus_b.busy),     32'd0);
        chk("b_sw1.addr", 32'(bus_b.mem_addr), 32'h40);
        req_b(1'b0, 32'h0, 3'b000, 32'h0);
        tick();
        chk("b_end.err", 32'(bus_b.err),    32'd0);
        chk("b_end.we",  32'(bus_b.mem_we), 32'd0);
        chk("b_end.rdy", 32'(bus_b.req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
